// File: rtl/rotary_quad_decoder.sv
// Quadrature rotary-encoder front end: synchronizes and debounces the A/B channels,
// then decodes full detents into one-clock step pulses with a sticky illegal-transition flag.
module rotary_quad_decoder #(
  parameter int TICK_DIV       = 2700,
  parameter int DEBOUNCE_COUNT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       clr_err,
  output logic       step_up,
  output logic       step_down,
  output logic       err,
  output logic [1:0] ab_state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Channel index 1 is A and index 0 is B, so the filtered vector is ab_state directly.
  logic [1:0]    meta_q, sync_q, filt_q;
  logic [4:0]    deb_cnt_q [2];
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  logic [1:0]        prev_q;
  logic signed [2:0] acc_q, acc_d;
  logic              step_up_q, step_up_d;
  logic              step_down_q, step_down_d;
  logic              err_q, err_d;

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      tick_cnt_q <= '0;
      for (int i = 0; i < 2; i++) deb_cnt_q[i] <= '0;
    end else begin
      meta_q     <= {enc_a, enc_b};
      sync_q     <= meta_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      if (tick) begin
        for (int i = 0; i < 2; i++) begin
          if (sync_q[i] != filt_q[i]) begin
            if (deb_cnt_q[i] == 5'(DEBOUNCE_COUNT - 1)) begin
              filt_q[i]    <= sync_q[i];
              deb_cnt_q[i] <= '0;
            end else begin
              deb_cnt_q[i] <= deb_cnt_q[i] + 5'd1;
            end
          end else begin
            deb_cnt_q[i] <= '0;
          end
        end
      end
    end
  end

  // Position along the clockwise cycle 11 -> 10 -> 00 -> 01.
  function automatic logic [1:0] cw_pos(input logic [1:0] ab);
    case (ab)
      2'b11:   cw_pos = 2'd0;
      2'b10:   cw_pos = 2'd1;
      2'b00:   cw_pos = 2'd2;
      default: cw_pos = 2'd3;
    endcase
  endfunction

  logic [1:0]        pos_step;
  logic signed [3:0] delta, sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    err_d       = err_q & ~clr_err;
    acc_d       = acc_q;
    pos_step    = cw_pos(ab_state) - cw_pos(prev_q);
    delta       = 4'sd0;
    if (pos_step == 2'd1)      delta = 4'sd1;
    else if (pos_step == 2'd3) delta = -4'sd1;
    sum = 4'(acc_q) + delta;

    if (pos_step == 2'd2) begin
      err_d = 1'b1;                      // set wins over clr_err
    end else if (pos_step != 2'd0) begin
      if (ab_state == 2'b11) begin
        step_up_d   = (sum == 4'sd4);
        step_down_d = (sum == -4'sd4);
        acc_d       = 3'sd0;
      end else if (sum > 4'sd3) begin
        acc_d = 3'sd3;
      end else if (sum < -4'sd3) begin
        acc_d = -3'sd3;
      end else begin
        acc_d = sum[2:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= 2'b11;
      acc_q       <= 3'sd0;
      step_up_q   <= 1'b0;
      step_down_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_q      <= ab_state;
      acc_q       <= acc_d;
      step_up_q   <= step_up_d;
      step_down_q <= step_down_d;
      err_q       <= err_d;
    end
  end

  assign ab_state  = filt_q;
  assign step_up   = step_up_q;
  assign step_down = step_down_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Scoreboard bench for rotary_quad_decoder: directed encoder sequences push expected
// step events; a monitor pops them whenever a step pulse appears.
module tb_rotary_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b1;
  logic       enc_b = 1'b1;
  logic       clr_err = 1'b0;
  logic       step_up, step_down, err;
  logic [1:0] ab_state;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected step events as {step_up, step_down}.
  logic [1:0] exp_q [$];
  logic [1:0] ab_h1 = 2'b11;
  logic [1:0] ab_h2 = 2'b11;

  rotary_quad_decoder #(.TICK_DIV(4), .DEBOUNCE_COUNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .clr_err   (clr_err),
    .step_up   (step_up),
    .step_down (step_down),
    .err       (err),
    .ab_state  (ab_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every step pulse consumes one expected event and must follow the
  // final transition into 11 by exactly one clock.
  always @(negedge clk) begin
    if (step_up || step_down) begin
      if (exp_q.size() == 0) begin
        check("unexpected_step", {30'd0, step_up, step_down}, 32'd0);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("step_dir", {30'd0, step_up, step_down}, {30'd0, e});
        check("step_latency", {28'd0, ab_h2, ab_h1},
              e[1] ? 32'b0111 : 32'b1011);
      end
    end
    ab_h2 = ab_h1;
    ab_h1 = ab_state;
  end

  task automatic drive(input logic [1:0] ab, input int hold);
    {enc_a, enc_b} = ab;
    repeat (hold) @(negedge clk);
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (4) @(negedge clk);
    check("rst_ab_state", ab_state, 2'b11);
    check("rst_step_up", step_up, 1'b0);
    check("rst_step_down", step_down, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Clean clockwise detent.
    exp_q.push_back(2'b10);
    drive(2'b10, 40); drive(2'b00, 40); drive(2'b01, 40); drive(2'b11, 40);
    check("cw_err", err, 1'b0);
    check("cw_ab_state", ab_state, 2'b11);
    check("cw_pending", exp_q.size(), 0);

    // Counter-clockwise detent.
    exp_q.push_back(2'b01);
    drive(2'b01, 40); drive(2'b00, 40); drive(2'b10, 40); drive(2'b11, 40);
    check("ccw_ab_state", ab_state, 2'b11);
    check("ccw_err", err, 1'b0);
    check("ccw_pending", exp_q.size(), 0);

    // Short glitch on A: two ticks of disagreement, below the debounce threshold.
    drive(2'b01, 8);
    check("glitch_mid_ab", ab_state, 2'b11);
    drive(2'b11, 40);
    check("glitch_ab_state", ab_state, 2'b11);
    check("glitch_deb_cnt", dut.deb_cnt_q[1], 5'd0);
    check("glitch_pending", exp_q.size(), 0);

    // Partial rotation that backs out.
    drive(2'b10, 40); drive(2'b00, 40);
    check("partial_acc_mid", 32'($signed(dut.acc_q)), 32'd2);
    drive(2'b10, 40); drive(2'b11, 40);
    check("partial_acc_end", 32'($signed(dut.acc_q)), 32'd0);
    check("partial_ab_state", ab_state, 2'b11);
    check("partial_pending", exp_q.size(), 0);

    // Illegal double-bit jumps, then clear.
    drive(2'b00, 40);
    check("illegal_err", err, 1'b1);
    check("illegal_ab_state", ab_state, 2'b00);
    drive(2'b11, 40);
    check("illegal_acc", 32'($signed(dut.acc_q)), 32'd0);
    pulse_clr();
    check("clr_err_clears", err, 1'b0);

    // Illegal transition in the same cycle as clr_err: set must win.
    {enc_a, enc_b} = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ab_state != 2'b11) seen = 1'b1;
    end
    check("set_wins_wait", seen, 1'b1);
    pulse_clr();
    check("set_wins_err", err, 1'b1);
    drive(2'b11, 40);
    pulse_clr();
    check("set_wins_cleared", err, 1'b0);
    check("illegal_pending", exp_q.size(), 0);

    // Reset in the middle of a clockwise detent.
    drive(2'b10, 40); drive(2'b00, 40);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ab_state", ab_state, 2'b11);
    check("midrst_step_up", step_up, 1'b0);
    check("midrst_step_down", step_down, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_acc", 32'($signed(dut.acc_q)), 32'd0);
    {enc_a, enc_b} = 2'b01;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(2'b01, 40); drive(2'b11, 40);
    check("midrst_final_ab", ab_state, 2'b11);
    check("midrst_final_err", err, 1'b0);
    check("midrst_pending", exp_q.size(), 0);

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
